// File: rtl/vend_credit_controller.sv
// Vending credit controller: two-slot coin arbitration, credit,
// timed dispense, change payout and cancel handling.
module vend_credit_controller #(
  parameter int PRICE           = 3,
  parameter int DISPENSE_CYCLES = 4,
  parameter int CW              = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_a_valid,
  input  logic [1:0]    coin_a_code,
  output logic          coin_a_ready,
  input  logic          coin_b_valid,
  input  logic [1:0]    coin_b_code,
  output logic          coin_b_ready,
  input  logic          cancel,
  output logic          dispense,
  output logic          change_pulse,
  output logic          reject,
  output logic          busy,
  output logic [CW-1:0] credit,
  output logic [7:0]    sale_count
);

  localparam int DW =
    (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST   = DW'(DISPENSE_CYCLES - 1);
  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

  typedef enum logic [1:0] {
    COLLECT,
    DISPENSE,
    CHANGE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] credit_q;
  logic [7:0]    sale_q;
  logic [DW-1:0] cnt_q;
  logic          rr_q;
  logic          reject_q;

  logic          a_live;
  logic          b_live;
  logic          open_w;
  logic          xfer;
  logic          xfer_a;
  logic [1:0]    code_sel;
  logic          coin_bad;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum_d;
  logic          sale_hit;

  // Arbitration: code 00 is no coin; rr_q=1 means slot B has priority.
  always_comb begin
    a_live       = coin_a_valid & (coin_a_code != 2'b00);
    b_live       = coin_b_valid & (coin_b_code != 2'b00);
    open_w       = (state_q == COLLECT) & ~cancel;
    coin_a_ready = open_w & a_live & (~b_live | ~rr_q);
    coin_b_ready = open_w & b_live & (~a_live | rr_q);
    xfer_a       = coin_a_ready;
    xfer         = coin_a_ready | coin_b_ready;
    code_sel     = xfer_a ? coin_a_code : coin_b_code;
    coin_bad     = xfer & (code_sel == 2'b11);
    coin_val     = coin_bad ? '0 : CW'(code_sel);
    sum_d        = credit_q + coin_val;
    sale_hit     = sum_d >= PRICE_C;
  end

  // Sequencer: collect coins, run the dispense timer, pay out change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      sale_q   <= '0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= coin_bad;
      if (xfer) rr_q <= xfer_a;
      unique case (state_q)
        COLLECT: begin
          if (cancel) begin
            if (credit_q != '0) state_q <= CHANGE;
          end else if (xfer && !coin_bad) begin
            if (sale_hit) begin
              credit_q <= sum_d - PRICE_C;
              sale_q   <= sale_q + 8'd1;
              cnt_q    <= '0;
              state_q  <= DISPENSE;
            end else begin
              credit_q <= sum_d;
            end
          end
        end
        DISPENSE: begin
          if (cnt_q == DLAST) begin
            cnt_q   <= '0;
            state_q <= (credit_q != '0) ? CHANGE : COLLECT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHANGE: begin
          credit_q <= credit_q - 1'b1;
          if (credit_q == CW'(1)) state_q <= COLLECT;
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign dispense     = (state_q == DISPENSE);
  assign change_pulse = (state_q == CHANGE);
  assign busy         = (state_q != COLLECT);
  assign reject       = reject_q;
  assign credit       = credit_q;
  assign sale_count   = sale_q;

endmodule

// File: tb/tb_vend_credit_controller.sv
// Bench for vend_credit_controller: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_vend_credit_controller;

  localparam int PRICE = 3;
  localparam int DC    = 4;
  localparam int CW    = 4;

  logic          clk;
  logic          rst;
  logic          coin_a_valid;
  logic [1:0]    coin_a_code;
  logic          coin_a_ready;
  logic          coin_b_valid;
  logic [1:0]    coin_b_code;
  logic          coin_b_ready;
  logic          cancel;
  logic          dispense;
  logic          change_pulse;
  logic          reject;
  logic          busy;
  logic [CW-1:0] credit;
  logic [7:0]    sale_count;

  int passed;
  int total;

  vend_credit_controller #(
    .PRICE(PRICE),
    .DISPENSE_CYCLES(DC),
    .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_a_valid(coin_a_valid),
    .coin_a_code(coin_a_code),
    .coin_a_ready(coin_a_ready),
    .coin_b_valid(coin_b_valid),
    .coin_b_code(coin_b_code),
    .coin_b_ready(coin_b_ready),
    .cancel(cancel),
    .dispense(dispense),
    .change_pulse(change_pulse),
    .reject(reject),
    .busy(busy),
    .credit(credit),
    .sale_count(sale_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Behavioural model: credit in units, dispense cycles left,
  // a flag for paying change, and which slot wins a tie.
  int m_credit;
  int m_sales;
  int m_disp;
  bit m_chg;
  bit m_prefer_b;
  bit m_rej;

  function automatic bit idle_now();
    return (m_disp == 0) && !m_chg && !cancel;
  endfunction

  function automatic bit exp_a();
    bit av = coin_a_valid && (coin_a_code != 2'd0);
    bit bv = coin_b_valid && (coin_b_code != 2'd0);
    return idle_now() && av && (!bv || !m_prefer_b);
  endfunction

  function automatic bit exp_b();
    bit av = coin_a_valid && (coin_a_code != 2'd0);
    bit bv = coin_b_valid && (coin_b_code != 2'd0);
    return idle_now() && bv && (!av || m_prefer_b);
  endfunction

  bit ta;
  bit tb;
  int code;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_credit   = 0;
      m_sales    = 0;
      m_disp     = 0;
      m_chg      = 0;
      m_prefer_b = 0;
      m_rej      = 0;
    end else begin
      ta    = exp_a();
      tb    = exp_b();
      m_rej = 0;
      if (ta || tb) m_prefer_b = ta;
      if (m_disp > 0) begin
        m_disp--;
        if (m_disp == 0 && m_credit > 0) m_chg = 1;
      end else if (m_chg) begin
        m_credit--;
        if (m_credit == 0) m_chg = 0;
      end else if (cancel) begin
        if (m_credit > 0) m_chg = 1;
      end else if (ta || tb) begin
        code = ta ? int'(coin_a_code) : int'(coin_b_code);
        if (code == 3) begin
          m_rej = 1;
        end else begin
          m_credit += code;
          if (m_credit >= PRICE) begin
            m_credit -= PRICE;
            m_sales = (m_sales + 1) % 256;
            m_disp  = DC;
          end
        end
      end
    end
  end

  // Every cycle: all outputs against the model, away from the edge.
  always @(negedge clk) begin
    chk("coin_a_ready", int'(coin_a_ready), int'(exp_a()));
    chk("coin_b_ready", int'(coin_b_ready), int'(exp_b()));
    chk("dispense", int'(dispense), int'(m_disp > 0));
    chk("change_pulse", int'(change_pulse), int'(m_chg));
    chk("busy", int'(busy), int'((m_disp > 0) || m_chg));
    chk("credit", int'(credit), m_credit);
    chk("sale_count", int'(sale_count), m_sales);
    chk("reject", int'(reject), int'(m_rej));
    chk("credit_bound", int'(int'(credit) <= PRICE + 1), 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    coin_a_valid = 0;
    coin_a_code  = 0;
    coin_b_valid = 0;
    coin_b_code  = 0;
    cancel       = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    step();
    step();
    rst = 1;
    step();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    idle_in();
    rst = 0;
    #2;
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sales", int'(sale_count), 0);
    do_reset();

    // Three 5c coins on slot A make an exact sale.
    coin_a_valid = 1;
    coin_a_code  = 2'b01;
    step();
    chk("t1_credit1", int'(credit), 1);
    step();
    chk("t1_credit2", int'(credit), 2);
    step();
    idle_in();
    chk("t1_sales", int'(sale_count), 1);
    for (int i = 0; i < DC; i++) begin
      chk("t1_disp", int'(dispense), 1);
      chk("t1_nochg", int'(change_pulse), 0);
      step();
    end
    chk("t1_disp_end", int'(dispense), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_credit0", int'(credit), 0);

    // Two 10c coins: sale plus one unit of change.
    coin_a_valid = 1;
    coin_a_code  = 2'b10;
    step();
    chk("t2_credit2", int'(credit), 2);
    step();
    idle_in();
    for (int i = 0; i < DC; i++) begin
      chk("t2_disp", int'(dispense), 1);
      chk("t2_credit1", int'(credit), 1);
      step();
    end
    chk("t2_chg", int'(change_pulse), 1);
    step();
    chk("t2_chg_end", int'(change_pulse), 0);
    chk("t2_credit0", int'(credit), 0);
    chk("t2_busy", int'(busy), 0);
    chk("t2_sales", int'(sale_count), 2);

    // Both slots busy: round-robin A, B, A.
    do_reset();
    coin_a_valid = 1;
    coin_a_code  = 2'b01;
    coin_b_valid = 1;
    coin_b_code  = 2'b01;
    #1;
    chk("t3_a_first", int'(coin_a_ready), 1);
    chk("t3_b_wait", int'(coin_b_ready), 0);
    step();
    chk("t3_a_wait", int'(coin_a_ready), 0);
    chk("t3_b_next", int'(coin_b_ready), 1);
    step();
    chk("t3_a_third", int'(coin_a_ready), 1);
    chk("t3_b_wait2", int'(coin_b_ready), 0);
    step();
    for (int i = 0; i < DC; i++) begin
      chk("t3_disp", int'(dispense), 1);
      chk("t3_a_low", int'(coin_a_ready), 0);
      chk("t3_b_low", int'(coin_b_ready), 0);
      if (i == DC - 1) idle_in();
      step();
    end
    chk("t3_credit0", int'(credit), 0);
    chk("t3_sales", int'(sale_count), 1);

    // Cancel beats a coin and refunds the held credit.
    coin_a_valid = 1;
    coin_a_code  = 2'b01;
    step();
    step();
    chk("t4_credit2", int'(credit), 2);
    cancel = 1;
    #1;
    chk("t4_a_blocked", int'(coin_a_ready), 0);
    step();
    idle_in();
    chk("t4_chg1", int'(change_pulse), 1);
    chk("t4_credit_hold", int'(credit), 2);
    step();
    chk("t4_chg2", int'(change_pulse), 1);
    step();
    chk("t4_chg_end", int'(change_pulse), 0);
    chk("t4_credit0", int'(credit), 0);

    // Invalid coin is swallowed with a reject pulse.
    coin_b_valid = 1;
    coin_b_code  = 2'b11;
    #1;
    chk("t5_b_ready", int'(coin_b_ready), 1);
    step();
    idle_in();
    chk("t5_reject", int'(reject), 1);
    chk("t5_credit", int'(credit), 0);
    step();
    chk("t5_reject_end", int'(reject), 0);
    cancel = 1;
    step();
    cancel = 0;
    chk("t5_cancel_busy", int'(busy), 0);
    chk("t5_cancel_chg", int'(change_pulse), 0);

    // Async reset in the middle of a dispense.
    coin_a_valid = 1;
    coin_a_code  = 2'b10;
    step();
    step();
    idle_in();
    chk("t6_credit1", int'(credit), 1);
    chk("t6_sales2", int'(sale_count), 2);
    step();
    chk("t6_disp_mid", int'(dispense), 1);
    #2;
    rst = 0;
    #1;
    chk("t6_disp_rst", int'(dispense), 0);
    chk("t6_credit_rst", int'(credit), 0);
    chk("t6_sales_rst", int'(sale_count), 0);
    #2;
    rst = 1;
    coin_a_valid = 1;
    coin_a_code  = 2'b01;
    step();
    step();
    step();
    idle_in();
    chk("t6_resale_disp", int'(dispense), 1);
    chk("t6_resale_cnt", int'(sale_count), 1);
    for (int i = 0; i < DC; i++) step();

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      coin_a_valid = ($urandom_range(0, 2) != 0);
      coin_a_code  = 2'($urandom_range(0, 3));
      coin_b_valid = ($urandom_range(0, 2) != 0);
      coin_b_code  = 2'($urandom_range(0, 3));
      cancel       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2;
        rst = 0;
        #3;
        rst = 1;
      end
      step();
    end
    idle_in();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
